add_multicycle: RTL and testbench

//  Parametrised multi-cycle adder/subtractor, successor to the fixed 16-bit ADD16.

---
 rtl/add_multicycle.sv | 113 +++++++++++
 tb/tb_add_multicycle.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/add_multicycle.sv
// add_multicycle: WIDTH-bit add/subtract, one SLICE-bit chunk per clock with a rippled carry,
// valid/ready on both sides.
module add_multicycle #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;

   if (SLICE < 1 || WIDTH % SLICE != 0) begin : g_bad_slice
      $error("add_multicycle: WIDTH must be a positive multiple of SLICE");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, shifted;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [SLICE:0]   part;

   // Operands shift right one slice per clock; finished result slices enter at the top of a_q,
   // so after the last slice a_q holds the whole sum and the low slice was always the live one.
   assign part = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};

   if (NSLICE == 1) begin : g_one
      assign shifted = part[SLICE-1:0];
   end else begin : g_many
      assign shifted = {part[SLICE-1:0], a_q[WIDTH-1:SLICE]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = RUN;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub | cin;
            idx_d   = '0;
         end
         RUN: begin
            a_d     = shifted;
            b_d     = b_q >> SLICE;
            carry_d = part[SLICE];
            idx_d   = idx_q + IW'(1);
            if (idx_q == IW'(NSLICE - 1)) begin
               state_d = DONE;
               sum_d   = shifted;
               cout_d  = part[SLICE];
               ovf_d   = (a_q[SLICE-1] == b_q[SLICE-1]) && (part[SLICE-1] != a_q[SLICE-1]);
               zero_d  = shifted == '0;
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
endmodule

// File: tb/tb_add_multicycle.sv
// tb_add_multicycle: three add_multicycle instances (SLICE 8, 32, 4) on shared operands,
// checked every cycle against a latency-aware arithmetic model.
module tb_add_multicycle;
   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, cin, sub;
   logic [31:0] a, b;
   logic [2:0]  ordy;
   logic        ir[3], ov[3], co[3], vf[3], zr[3];
   logic [31:0] sum_w[3];
   int          checks = 0, passed = 0;
   int          ph[3], k[3];
   res_t        exp_r[3], held[3];
   bit          rnd = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      add_multicycle #(.WIDTH(32), .SLICE(g == 0 ? 8 : (g == 1 ? 32 : 4))) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
         .a(a), .b(b), .cin(cin), .sub(sub),
         .out_valid(ov[g]), .out_ready(ordy[g]),
         .sum(sum_w[g]), .cout(co[g]), .ovf(vf[g]), .zero(zr[g])
      );
   end

   function automatic int ns(int i);
      return i == 0 ? 4 : (i == 1 ? 1 : 8);
   endfunction

   // Reference arithmetic: unsigned sum for result/carry, signed range test for overflow.
   function automatic res_t model(logic [31:0] x, logic [31:0] y, logic ci, logic sb);
      res_t        r;
      logic [32:0] u;
      longint      t;
      if (sb) begin
         u   = {1'b0, x} - {1'b0, y};
         r.c = x >= y;
         t   = longint'($signed(x)) - longint'($signed(y));
      end else begin
         u   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
         r.c = u[32];
         t   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      end
      r.s = u[31:0];
      r.v = t > 64'sd2147483647 || t < -64'sd2147483648;
      r.z = r.s == 32'd0;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act === want) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, want);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ph: 0 idle, 1 computing (k edges left), 2 result presented
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            ph[i]   = 0;
            held[i] = '0;
         end
         chk($sformatf("u%0d in_ready", i), 64'(ir[i]), 64'(ph[i] == 0));
         chk($sformatf("u%0d out_valid", i), 64'(ov[i]), 64'(ph[i] == 2));
         chk($sformatf("u%0d result", i), 64'({sum_w[i], co[i], vf[i], zr[i]}),
             64'(ph[i] == 2 ? exp_r[i] : held[i]));
         if (rst_n) begin
            if (ph[i] == 0 && in_valid) begin
               ph[i]    = 1;
               k[i]     = ns(i);
               exp_r[i] = model(a, b, cin, sub);
            end else if (ph[i] == 1) begin
               k[i]--;
               if (k[i] == 0) ph[i] = 2;
            end else if (ph[i] == 2 && ordy[i]) begin
               ph[i]   = 0;
               held[i] = exp_r[i];
            end
         end
      end
   end

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                         input logic sb, output res_t r, output int lat);
      int m;
      step();
      a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
      step();
      in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!ov[0] && lat < 20) begin
         ordy = rnd ? 3'($urandom) : 3'b111;
         step();
         lat++;
      end
      r = {sum_w[0], co[0], vf[0], zr[0]};
      m = 0;
      while (!(ir[0] && ir[1] && ir[2]) && m < 200) begin
         ordy = rnd ? 3'($urandom) : 3'b111;
         step();
         m++;
      end
      chk("return to idle", 64'(m < 200), 64'(1));
      ordy = 3'b111;
   endtask

   task automatic dir(input string nm, input logic [31:0] x, input logic [31:0] y,
                      input logic ci, input logic sb, input res_t want);
      res_t r;
      int   lat;
      chk({nm, " model"}, 64'(model(x, y, ci, sb)), 64'(want));
      run_op(x, y, ci, sb, r, lat);
      chk({nm, " dut"}, 64'(r), 64'(want));
      chk({nm, " latency"}, 64'(lat), 64'(4));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      res_t r;
      int   lat, n;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; ordy = 3'b111;
      step();
      step();
      chk("reset in_ready", 64'(ir[0]), 64'(1));
      chk("reset out_valid", 64'(ov[0]), 64'(0));
      chk("reset sum", 64'(sum_w[0]), 64'(0));
      rst_n = 1'b1;

      dir("add carry ripple", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 1'b0});
      dir("add wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b1});
      dir("add cin", 32'hABCD_0000, 32'h1234_0000, 1'b1, 1'b0, '{32'hBE01_0001, 1'b0, 1'b0, 1'b0});
      dir("add ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
      dir("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      dir("sub 7-5 cin ignored", 32'd7, 32'd5, 1'b1, 1'b1, '{32'h2, 1'b1, 1'b0, 1'b0});
      dir("sub ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      dir("sub zero", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b1});

      // backpressure: hold all results, poke in_valid while DONE
      ordy = 3'b000;
      step();
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!(ov[0] && ov[1] && ov[2]) && n < 20) begin
         step();
         n++;
      end
      chk("bp reach done", 64'(n < 20), 64'(1));
      repeat (3) begin
         in_valid = 1'b1; a = $urandom; b = $urandom;
         step();
         chk("bp sum held", 64'(sum_w[0]), 64'(32'h2345_6789));
         chk("bp in_ready low", 64'(ir[0]), 64'(0));
         chk("bp out_valid high", 64'(ov[0]), 64'(1));
      end
      in_valid = 1'b0; ordy = 3'b111;
      step();
      chk("bp release in_ready", 64'(ir[0]), 64'(1));
      chk("bp release out_valid", 64'(ov[0]), 64'(0));
      chk("bp release sum kept", 64'(sum_w[0]), 64'(32'h2345_6789));

      // async reset during the second RUN clock
      step();
      a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d async in_ready", i), 64'(ir[i]), 64'(1));
         chk($sformatf("u%0d async outs", i), 64'({ov[i], sum_w[i], co[i], vf[i], zr[i]}), 64'(0));
      end
      step();
      step();
      rst_n = 1'b1;
      dir("after reset 1+1", 32'h1, 32'h1, 1'b0, 1'b0, '{32'h2, 1'b0, 1'b0, 1'b0});

      rnd = 1'b1;
      repeat (60) begin
         run_op(pick(), pick(), 1'($urandom), 1'($urandom), r, lat);
         chk("random latency", 64'(lat), 64'(4));
      end

      step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
